mmv_output_gather: RTL and testbench

Output-side companion to the MMV input sliding-window unit. It accepts a single-pixel stream of PE-wide channel-fold words from the compute array, then reorders and packs MMV consecutive output pixels into one MMV-lane word per channel fold. Words leave pixel-group-major, fold-minor, which is the lane layout the downstream MMV-wide consumers read. Ping-pong buffering lets one pixel group fill while the previous group drains.

---
 rtl/mmv_output_gather_if.sv | 12 +
 rtl/mmv_output_gather.sv | 142 ++++++++++++++
 tb/tb_mmv_output_gather.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mmv_output_gather_if.sv
// AXI-stream style channel (data, valid, ready) shared by the input and output
// sides of mmv_output_gather.
interface mmv_output_gather_if #(
    parameter int DW = 8
);
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/mmv_output_gather.sv
// Packs MMV consecutive output pixels into one MMV-lane word per channel fold,
// using two ping-pong banks so one pixel group fills while the other drains.
module mmv_output_gather #(
    parameter int PE           = 1,
    parameter int OP_PRECISION = 8,
    parameter int MMV          = 2,
    parameter int CHANNELS     = 2,
    parameter int OFMWidth     = 6,
    parameter int OFMHeight    = 6
) (
    input  logic                  clk,
    input  logic                  resetn,
    mmv_output_gather_if.slave    ip_axis,
    mmv_output_gather_if.master   op_axis
);
    localparam int W    = PE * OP_PRECISION;
    localparam int FOLD = CHANNELS / PE;
    localparam int NPIX = OFMWidth * OFMHeight;
    localparam int FW   = (FOLD > 1) ? $clog2(FOLD) : 1;
    localparam int LW   = (MMV > 1) ? $clog2(MMV) : 1;
    localparam int PW   = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int NW   = $clog2(MMV + 1);

    logic [W-1:0]     mem_r [2][MMV][FOLD];
    logic [1:0]       full_r;
    logic [NW-1:0]    nl_r [2];

    logic             wsel_r;
    logic [LW-1:0]    wl_r;
    logic [FW-1:0]    wf_r;
    logic [PW-1:0]    wpix_r;

    logic             rsel_r;
    logic [FW-1:0]    rf_r;
    logic             op_tvalid_r;
    logic [MMV*W-1:0] op_tdata_r;

    logic             ip_accept_s;
    logic             wlast_fold_s;
    logic             close_s;
    logic             load_s;
    logic             rlast_s;
    logic             rdone_s;
    logic [1:0]       set_mask_s;
    logic [1:0]       clr_mask_s;
    logic [MMV*W-1:0] load_data_s;

    assign ip_axis.tready = resetn & ~full_r[wsel_r];
    assign ip_accept_s    = ip_axis.tvalid & ip_axis.tready;
    assign wlast_fold_s   = (wf_r == FW'(FOLD - 1));
    // A group closes on its last fold, either when all lanes are used or the frame ends.
    assign close_s        = ip_accept_s & wlast_fold_s &
                            ((wl_r == LW'(MMV - 1)) | (wpix_r == PW'(NPIX - 1)));

    assign load_s         = full_r[rsel_r] & (~op_tvalid_r | op_axis.tready);
    assign rlast_s        = (rf_r == FW'(FOLD - 1));
    assign rdone_s        = load_s & rlast_s;

    // Set and clear always target different banks, so they merge without priority.
    assign set_mask_s     = close_s ? (wsel_r ? 2'b10 : 2'b01) : 2'b00;
    assign clr_mask_s     = rdone_s ? (rsel_r ? 2'b10 : 2'b01) : 2'b00;

    assign op_axis.tvalid = op_tvalid_r;
    assign op_axis.tdata  = op_tdata_r;

    // Bank storage: one entry written per accepted input word.
    always_ff @(posedge clk) begin
        if (ip_accept_s) begin
            mem_r[wsel_r][wl_r][wf_r] <= ip_axis.tdata;
        end
    end

    // Write-side lane/fold/pixel counters and bank select.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wsel_r <= 1'b0;
            wl_r   <= '0;
            wf_r   <= '0;
            wpix_r <= '0;
        end else if (ip_accept_s) begin
            if (wlast_fold_s) begin
                wf_r   <= '0;
                wpix_r <= (wpix_r == PW'(NPIX - 1)) ? '0 : wpix_r + 1'b1;
                if (close_s) begin
                    wl_r   <= '0;
                    wsel_r <= ~wsel_r;
                end else begin
                    wl_r   <= wl_r + 1'b1;
                end
            end else begin
                wf_r <= wf_r + 1'b1;
            end
        end
    end

    // Bank full flags and the number of valid lanes captured at group close.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            full_r   <= 2'b00;
            nl_r[0]  <= '0;
            nl_r[1]  <= '0;
        end else begin
            full_r <= (full_r | set_mask_s) & ~clr_mask_s;
            if (close_s) begin
                nl_r[wsel_r] <= NW'(wl_r) + NW'(1'b1);
            end
        end
    end

    // Gather one fold across all lanes of the read bank, zeroing unused lanes.
    always_comb begin
        load_data_s = '0;
        for (int j = 0; j < MMV; j++) begin
            if (NW'(j) < nl_r[rsel_r]) begin
                load_data_s[j*W +: W] = mem_r[rsel_r][j][rf_r];
            end else begin
                load_data_s[j*W +: W] = '0;
            end
        end
    end

    // Output register and read-side fold counter / bank select.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rsel_r      <= 1'b0;
            rf_r        <= '0;
            op_tvalid_r <= 1'b0;
            op_tdata_r  <= '0;
        end else if (load_s) begin
            op_tdata_r  <= load_data_s;
            op_tvalid_r <= 1'b1;
            if (rlast_s) begin
                rf_r   <= '0;
                rsel_r <= ~rsel_r;
            end else begin
                rf_r   <= rf_r + 1'b1;
            end
        end else if (op_tvalid_r & op_axis.tready) begin
            op_tvalid_r <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mmv_output_gather.sv
// Randomized self-checking bench for mmv_output_gather against a frame-level
// reference model (pixel/fold arrays, grouped into expected MMV-lane words).
module tb_mmv_output_gather;
    localparam int PE           = 2;
    localparam int OP_PRECISION = 8;
    localparam int MMV          = 2;
    localparam int CHANNELS     = 4;
    localparam int OFMWidth     = 3;
    localparam int OFMHeight    = 3;
    localparam int W    = PE * OP_PRECISION;
    localparam int FOLD = CHANNELS / PE;
    localparam int NPIX = OFMWidth * OFMHeight;
    localparam int OW   = MMV * W;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    mmv_output_gather_if #(.DW(W))  ip_if ();
    mmv_output_gather_if #(.DW(OW)) op_if ();

    mmv_output_gather #(
        .PE(PE), .OP_PRECISION(OP_PRECISION), .MMV(MMV),
        .CHANNELS(CHANNELS), .OFMWidth(OFMWidth), .OFMHeight(OFMHeight)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .ip_axis(ip_if),
        .op_axis(op_if)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: frame-indexed pixel store; a finished group yields FOLD words.
    logic [W-1:0]  pix_mem [NPIX][FOLD];
    int            acc_k = 0;
    logic [OW-1:0] exp_q [$];

    task automatic model_accept(input logic [W-1:0] d);
        int p;
        int f;
        int g;
        logic [OW-1:0] word;
        p = acc_k / FOLD;
        f = acc_k % FOLD;
        pix_mem[p][f] = d;
        if (f == FOLD - 1 && ((p % MMV) == MMV - 1 || p == NPIX - 1)) begin
            g = p / MMV;
            for (int ff = 0; ff < FOLD; ff++) begin
                word = '0;
                for (int j = 0; j < MMV; j++) begin
                    if (g * MMV + j <= p) word[j*W +: W] = pix_mem[g*MMV + j][ff];
                end
                exp_q.push_back(word);
            end
        end
        acc_k = (acc_k + 1) % (NPIX * FOLD);
    endtask

    // Monitor: sampled on the falling edge, half a cycle from the active edge.
    int rst_cycles = 0;
    always @(negedge clk) begin
        if (!resetn) begin
            check("rst_iready", 64'(ip_if.tready), 64'd0);
            if (rst_cycles > 0) begin
                check("rst_ovalid", 64'(op_if.tvalid), 64'd0);
                check("rst_odata", 64'(op_if.tdata), 64'd0);
            end
            rst_cycles++;
            acc_k = 0;
            exp_q.delete();
        end else begin
            rst_cycles = 0;
            if (op_if.tvalid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", 64'd1, 64'd0);
                end else begin
                    check("odata", 64'(op_if.tdata), 64'(exp_q[0]));
                    if (op_if.tready) void'(exp_q.pop_front());
                end
            end
            if (ip_if.tvalid && ip_if.tready) model_accept(ip_if.tdata);
        end
    end

    // Output ready generator: 0 = held low, 1 = held high, otherwise random.
    int ordy_mode = 0;
    always @(posedge clk) begin
        #2;
        case (ordy_mode)
            0:       op_if.tready = 1'b0;
            1:       op_if.tready = 1'b1;
            default: op_if.tready = 1'($urandom_range(0, 1));
        endcase
    end

    function automatic logic [W-1:0] base_word(input int i);
        return W'(32'(i) * 32'h0000_0137 + 32'h0000_2A05);
    endfunction

    task automatic send(input logic [W-1:0] d, input bit nostall);
        int waits;
        waits = 0;
        ip_if.tvalid = 1'b1;
        ip_if.tdata  = d;
        @(negedge clk);
        while (!ip_if.tready && waits < 200) begin
            waits++;
            @(negedge clk);
        end
        if (waits >= 200) check("in_timeout", 64'd1, 64'd0);
        if (nostall) check("in_stall", 64'(waits), 64'd0);
        @(posedge clk);
        #1;
        ip_if.tvalid = 1'b0;
    endtask

    task automatic wait_drain();
        int c;
        c = 0;
        while ((exp_q.size() != 0 || op_if.tvalid) && c < 300) begin
            @(negedge clk);
            c++;
        end
        check("drain_left", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int cnt;
        int n;
        ip_if.tvalid = 1'b0;
        ip_if.tdata  = '0;
        op_if.tready = 1'b0;
        resetn       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;

        // Basic pack with partial final group, plus first-output latency.
        ordy_mode = 1;
        for (int i = 0; i < NPIX * FOLD; i++) begin
            send(base_word(i), 1'b0);
            if (i == MMV * FOLD - 1) begin
                @(negedge clk);
                check("lat_edge", 64'(op_if.tvalid), 64'd0);
                @(negedge clk);
                check("lat_edge_plus1", 64'(op_if.tvalid), 64'd1);
                @(posedge clk);
                #1;
            end
        end
        wait_drain();

        // Full-rate streaming: no input stall after the first accept.
        for (int i = 0; i < NPIX * FOLD; i++) send(W'($urandom), i > 0);
        wait_drain();

        // Backpressure: both banks fill, then release.
        ordy_mode = 0;
        cnt = 0;
        ip_if.tvalid = 1'b1;
        ip_if.tdata  = W'($urandom);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (!ip_if.tready) break;
            cnt++;
            @(posedge clk);
            #1;
            ip_if.tdata = W'($urandom);
        end
        check("bp_accepts", 64'(cnt), 64'(2 * MMV * FOLD));
        repeat (3) begin
            @(negedge clk);
            check("bp_iready_low", 64'(ip_if.tready), 64'd0);
        end
        check("bp_ovalid", 64'(op_if.tvalid), 64'd1);
        @(posedge clk);
        #1;
        ordy_mode = 1;
        @(negedge clk);
        check("bp_iready_pre", 64'(ip_if.tready), 64'd0);
        @(negedge clk);
        check("bp_iready_free", 64'(ip_if.tready), 64'd1);
        @(posedge clk);
        #1;
        ip_if.tvalid = 1'b0;
        for (int i = cnt + 1; i < NPIX * FOLD; i++) send(W'($urandom), 1'b0);
        wait_drain();

        // Random valid/ready toggling across two back-to-back frames.
        ordy_mode = 2;
        for (int i = 0; i < 2 * NPIX * FOLD; i++) begin
            n = $urandom_range(0, 2);
            repeat (n) begin
                @(posedge clk);
                #1;
            end
            send(W'($urandom), 1'b0);
        end
        wait_drain();

        // Reset with both banks full and a word pending, then a fresh frame.
        ordy_mode = 0;
        for (int i = 0; i < 2 * MMV * FOLD; i++) send(W'($urandom), 1'b0);
        ip_if.tvalid = 1'b1;
        ip_if.tdata  = W'($urandom);
        @(posedge clk);
        #1;
        resetn = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        ip_if.tvalid = 1'b0;
        resetn = 1'b1;
        ordy_mode = 1;
        for (int i = 0; i < NPIX * FOLD; i++) send(base_word(i), 1'b0);
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
